uint_to_float_conv: RTL
=======================

// Module: uint_to_float_conv
// PURPOSE
//  Multi-cycle converter from a 32-bit unsigned integer to an IEEE-754 single-precision float (FCVT.S.WU).
//  Sits upstream of the float-to-unsigned-int converter in the FPU datapath.
//  Feeds the float operand bus and the FPU result mux.
//  Normalisation is serial (one bit per cycle) to keep area small.
//  Rounding is fixed to round-to-nearest-even; an inexact flag is produced for fflags.
// PARAMETERS
//  none (integer width 32, float format binary32: both fixed)
// PORTS
//  clk           input   1   system clock; all state on rising edge
//  rst           input   1   asynchronous, active-high reset
//  input_a       input   32  unsigned integer operand
//  input_a_stb   input   1   operand valid; sampled only when busy==0
//  busy          output  1   high from accept edge until return to IDLE
//  output_z      output  32  float result; held until next result
//  output_z_stb  output  1   one-cycle pulse: output_z/output_nx valid
//  output_nx     output  1   inexact (any discarded bit nonzero)
// BEHAVIOUR
//  Reset (async, rst=1)
//   - state=IDLE; output_z=0, output_z_stb=0, output_nx=0, busy=0.
//   - Reset mid-conversion aborts the operation with no stb; internal value, exp and mant are cleared.
//  FSM states: IDLE, NORM, ROUND, PACK
//   - IDLE: if input_a_stb, then value<=input_a, exp<=158 (127+31), busy<=1, state<=NORM.
//     input_a_stb while busy is ignored (no queueing).
//   - NORM:
//       value==0        -> state<=PACK, zero flag set.
//       else value[31]==0 -> value<<=1, exp<=exp-1.
//       else            -> state<=ROUND.
//   - ROUND: mant=value[30:8]; G=value[7]; R=value[6]; S=|value[5:0].
//       Round up when G & (R|S|mant[0]). Increment carry out of mant[22:0] -> mant=0, exp=exp+1.
//       nx=G|R|S. state<=PACK.
//   - PACK: output_z<={1'b0,exp[7:0],mant} (zero case: 32'h0, nx=0).
//       output_z_stb<=1 for exactly one cycle; output_nx<=nx; busy<=0; state<=IDLE.
//  Sign bit is always 0; exp never exceeds 159, so no overflow/inf/NaN paths exist.
//  Latency, with lz = leading zeros of input_a and E0 the accept edge:
//   - Nonzero: output_z_stb is set at edge E0+lz+3 (min 3, max 34 cycles).
//   - Zero: output_z_stb is set at E0+2.
//  Throughput: next operand is accepted no earlier than the edge after the stb pulse begins (busy=0 then).
//  output_z is stable between pulses; output_z_stb is never high for 2 consecutive cycles.
// TESTING
//  1. Reset held 9 ns, then input_a=32'h2 with stb pulse.
//     -> output_z=32'h40000000, nx=0, stb 33 cycles after accept.
//  2. input_a=7 -> output_z=32'h40E00000, nx=0.
//     input_a=1 -> 32'h3F800000 after 34 cycles.
//     input_a=0 -> 32'h0 after 2 cycles.
//  3. Rounding:
//     - 32'h01000001 -> 32'h4B800000, nx=1 (tie to even, down).
//     - 32'h01000003 -> 32'h4B800002, nx=1 (tie to even, up).
//     - 32'h01000002 -> 32'h4B800001, nx=0.
//  4. Carry: 32'hFFFFFFFF -> 32'h4F800000, nx=1 (mantissa overflow bumps exp to 159).
//     32'h80000000 -> 32'h4F000000 after 3 cycles.
//  5. Handshake: hold input_a_stb high with changing input_a during busy.
//     -> only the first operand is converted; one stb pulse per accept; busy low exactly when IDLE.
//  6. Assert rst mid-NORM (input 1, 10 cycles in).
//     -> outputs 0 immediately, no stb.
//     New input 7 after release -> 32'h40E00000.

Source files
------------

// File: rtl/uint_to_float_conv.sv
//------------------------------------------------------------------------------
// uint_to_float_conv : serial 32-bit unsigned integer to binary32 converter (RNE)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uint_to_float_conv (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        busy,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  output logic        output_nx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_PACK  = 2'd3
  } state_t;

  localparam logic [7:0] c_EXP_INIT = 8'd158;

  state_t      state_q, state_d;
  logic [31:0] value_q, value_d;
  logic [7:0]  exp_q, exp_d;
  logic [22:0] mant_q, mant_d;
  logic        nx_q, nx_d;
  logic        zero_q, zero_d;
  logic        busy_q, busy_d;
  logic [31:0] z_q, z_d;
  logic        stb_q, stb_d;
  logic        onx_q, onx_d;

  logic        w_guard, w_round, w_sticky, w_round_up;
  logic [23:0] w_mant_inc;

  // Once normalised, value_q[31] is the hidden one; the next 23 bits are the
  // mantissa and everything below feeds guard/round/sticky.
  assign w_guard    = value_q[7];
  assign w_round    = value_q[6];
  assign w_sticky   = |value_q[5:0];
  assign w_round_up = w_guard & (w_round | w_sticky | value_q[8]);
  assign w_mant_inc = {1'b0, value_q[30:8]} + 24'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      value_q <= '0;
      exp_q   <= '0;
      mant_q  <= '0;
      nx_q    <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      z_q     <= '0;
      stb_q   <= 1'b0;
      onx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      nx_q    <= nx_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      z_q     <= z_d;
      stb_q   <= stb_d;
      onx_q   <= onx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    nx_d    = nx_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    z_d     = z_q;
    stb_d   = 1'b0;
    onx_d   = onx_q;

    case (state_q)
      S_IDLE: begin
        if (input_a_stb) begin
          value_d = input_a;
          exp_d   = c_EXP_INIT;
          nx_d    = 1'b0;
          zero_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (value_q == 32'd0) begin
          zero_d  = 1'b1;
          state_d = S_PACK;
        end else if (!value_q[31]) begin
          value_d = {value_q[30:0], 1'b0};
          exp_d   = exp_q - 8'd1;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        // A carry out of the incremented mantissa leaves it all-zero and
        // bumps the exponent by one.
        mant_d  = w_round_up ? w_mant_inc[22:0] : value_q[30:8];
        exp_d   = exp_q + {7'd0, w_round_up & w_mant_inc[23]};
        nx_d    = w_guard | w_round | w_sticky;
        state_d = S_PACK;
      end
      S_PACK: begin
        z_d     = zero_q ? 32'd0 : {1'b0, exp_q, mant_q};
        onx_d   = zero_q ? 1'b0 : nx_q;
        stb_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy         = busy_q;
  assign output_z     = z_q;
  assign output_z_stb = stb_q;
  assign output_nx    = onx_q;

endmodule

`default_nettype wire
